// File: rtl/burglar_alarm_ctrl.sv
// burglar_alarm_ctrl: clocked, N-zone burglar alarm controller.
// Provides per-zone bypass, timed exit and entry delays, latched per-zone
// alarm memory, and a siren with a bounded on-time.
// Optional feature macro: BURGLAR_TAMPER_EN adds the tamper input, which
// forces ALARM from any state and outranks disarm.
module burglar_alarm_ctrl #(
  parameter int N_ZONES   = 8,
  parameter int EXIT_DLY  = 16,
  parameter int ENTRY_DLY = 8,
  parameter int SIREN_CYC = 32
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [N_ZONES-1:0] zoneOpen,
  input  logic [N_ZONES-1:0] zoneBypass,
  input  logic               armReq,
  input  logic               disarmReq,
`ifdef BURGLAR_TAMPER_EN
  input  logic               tamper,
`endif
  output logic [N_ZONES-1:0] alarmEnable,
  output logic               siren,
  output logic               armed,
  output logic               armFail,
  output logic [2:0]         state
);

  // The counter only has to hold the largest delay minus one.
  localparam int MAX_ED  = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
  localparam int MAX_DLY = (MAX_ED > SIREN_CYC) ? MAX_ED : SIREN_CYC;
  localparam int CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DLY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DLY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  state_t             cur_state;
  state_t             nxt_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [N_ZONES-1:0] mem_nxt;
  logic               fail_nxt;
  logic               siren_nxt;
  logic               armed_nxt;
  logic [N_ZONES-1:0] act;
  logic               tamper_hit;

  // Bypassed zones are masked out before any decision is made.
  assign act = zoneOpen & ~zoneBypass;

`ifdef BURGLAR_TAMPER_EN
  assign tamper_hit = tamper;
`else
  assign tamper_hit = 1'b0;
`endif

  // Next-state, counter, alarm memory and registered-output decode.
  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = cnt;
    mem_nxt   = alarmEnable;
    fail_nxt  = 1'b0;
    if (tamper_hit) begin
      // Tamper restarts a full siren period and leaves the memory alone.
      nxt_state = S_ALARM;
      cnt_nxt   = SIREN_LOAD;
    end else begin
      case (cur_state)
        S_DISARMED: begin
          if (disarmReq) begin
            nxt_state = S_DISARMED;
          end else if (armReq) begin
            if (act == '0) begin
              nxt_state = S_EXIT;
              cnt_nxt   = EXIT_LOAD;
              mem_nxt   = '0;
            end else begin
              fail_nxt  = 1'b1;
            end
          end
        end
        S_EXIT: begin
          if (disarmReq) begin
            nxt_state = S_DISARMED;
            cnt_nxt   = CNT_ZERO;
          end else if (cnt == CNT_ZERO) begin
            nxt_state = S_ARMED;
          end else begin
            cnt_nxt   = cnt - CNT_ONE;
          end
        end
        S_ARMED: begin
          if (disarmReq) begin
            nxt_state = S_DISARMED;
            cnt_nxt   = CNT_ZERO;
          end else if (act != '0) begin
            nxt_state = S_ENTRY;
            cnt_nxt   = ENTRY_LOAD;
            mem_nxt   = alarmEnable | act;
          end
        end
        S_ENTRY: begin
          if (disarmReq) begin
            nxt_state = S_DISARMED;
            cnt_nxt   = CNT_ZERO;
          end else begin
            mem_nxt = alarmEnable | act;
            if (cnt == CNT_ZERO) begin
              nxt_state = S_ALARM;
              cnt_nxt   = SIREN_LOAD;
            end else begin
              cnt_nxt   = cnt - CNT_ONE;
            end
          end
        end
        S_ALARM: begin
          if (disarmReq) begin
            nxt_state = S_DISARMED;
            cnt_nxt   = CNT_ZERO;
          end else begin
            mem_nxt = alarmEnable | act;
            if (cnt == CNT_ZERO) begin
              // Still-open zones are picked up by ARMED one cycle later.
              nxt_state = S_ARMED;
            end else begin
              cnt_nxt   = cnt - CNT_ONE;
            end
          end
        end
        default: begin
          // Encodings 5..7 are unreachable; recover to a safe state.
          nxt_state = S_DISARMED;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
    siren_nxt = (nxt_state == S_ALARM);
    armed_nxt = (nxt_state == S_ARMED) || (nxt_state == S_ENTRY) ||
                (nxt_state == S_ALARM);
  end

  // State, counter and all outputs are registered; reset aborts at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur_state   <= S_DISARMED;
      cnt         <= CNT_ZERO;
      alarmEnable <= '0;
      siren       <= 1'b0;
      armed       <= 1'b0;
      armFail     <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      cnt         <= cnt_nxt;
      alarmEnable <= mem_nxt;
      siren       <= siren_nxt;
      armed       <= armed_nxt;
      armFail     <= fail_nxt;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_burglar_alarm_ctrl.sv
// Testbench for burglar_alarm_ctrl: directed scenarios followed by random
// stimulus, checked by a timestamp-based reference model via a scoreboard.
module tb_burglar_alarm_ctrl;
  localparam int N         = 8;
  localparam int EXIT_DLY  = 16;
  localparam int ENTRY_DLY = 8;
  localparam int SIREN_CYC = 32;
`ifdef BURGLAR_TAMPER_EN
  localparam bit TAMPER_BUILD = 1'b1;
`else
  localparam bit TAMPER_BUILD = 1'b0;
`endif

  // Mode numbers are the state encodings the controller reports.
  localparam int M_DIS = 0, M_EXIT = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4;

  logic         clk = 1'b0;
  logic         resetN;
  logic [N-1:0] zoneOpen, zoneBypass;
  logic         armReq, disarmReq, tamper;
  logic [N-1:0] alarmEnable;
  logic         siren, armed, armFail;
  logic [2:0]   state;

  burglar_alarm_ctrl #(
    .N_ZONES(N), .EXIT_DLY(EXIT_DLY), .ENTRY_DLY(ENTRY_DLY), .SIREN_CYC(SIREN_CYC)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .zoneOpen(zoneOpen),
    .zoneBypass(zoneBypass),
    .armReq(armReq),
    .disarmReq(disarmReq),
`ifdef BURGLAR_TAMPER_EN
    .tamper(tamper),
`endif
    .alarmEnable(alarmEnable),
    .siren(siren),
    .armed(armed),
    .armFail(armFail),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   st;
    logic [N-1:0] mem;
    logic         sir;
    logic         arm;
    logic         fail;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: a mode plus the absolute clock-edge index at which the
  // current timed mode ends.
  int           m_mode;
  int           m_edge;
  int           m_leave;
  logic [N-1:0] m_mem;
  logic         m_fail;

  function automatic void model_reset();
    m_mode  = M_DIS;
    m_leave = 0;
    m_mem   = '0;
    m_fail  = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] op, byp,
                                     input logic ar, ds, tp);
    logic [N-1:0] a;
    a      = op & ~byp;
    m_edge = m_edge + 1;
    m_fail = 1'b0;
    if (tp && TAMPER_BUILD) begin
      m_mode  = M_ALARM;
      m_leave = m_edge + SIREN_CYC;
    end else if (ds) begin
      m_mode = M_DIS;
    end else begin
      case (m_mode)
        M_DIS: if (ar) begin
          if (a == 0) begin
            m_mode  = M_EXIT;
            m_leave = m_edge + EXIT_DLY;
            m_mem   = '0;
          end else m_fail = 1'b1;
        end
        M_EXIT:  if (m_edge == m_leave) m_mode = M_ARMED;
        M_ARMED: if (a != 0) begin
          m_mode  = M_ENTRY;
          m_leave = m_edge + ENTRY_DLY;
          m_mem   = m_mem | a;
        end
        M_ENTRY: begin
          m_mem = m_mem | a;
          if (m_edge == m_leave) begin
            m_mode  = M_ALARM;
            m_leave = m_edge + SIREN_CYC;
          end
        end
        default: begin
          m_mem = m_mem | a;
          if (m_edge == m_leave) m_mode = M_ARMED;
        end
      endcase
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.st   = 3'(m_mode);
    o.mem  = m_mem;
    o.sir  = (m_mode == M_ALARM);
    o.arm  = (m_mode == M_ARMED) || (m_mode == M_ENTRY) || (m_mode == M_ALARM);
    o.fail = m_fail;
    return o;
  endfunction

  // Drive one input vector before the next rising edge and queue the result.
  task automatic apply(input logic [N-1:0] op, byp, input logic ar, ds, tp);
    @(negedge clk);
    resetN     = 1'b1;
    zoneOpen   = op;
    zoneBypass = byp;
    armReq     = ar;
    disarmReq  = ds;
    tamper     = tp;
    model_step(op, byp, ar, ds, tp);
    exp_q.push_back(model_obs());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", {alarmEnable, siren, armed, armFail}, 32'd0);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  // Monitor: every rising edge produces a new registered output vector.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        g.st   = state;
        g.mem  = alarmEnable;
        g.sir  = siren;
        g.arm  = armed;
        g.fail = armFail;
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL scoreboard: got st=%0d mem=%h sir=%b arm=%b fail=%b expected st=%0d mem=%h sir=%b arm=%b fail=%b at %0t",
                   g.st, g.mem, g.sir, g.arm, g.fail, e.st, e.mem, e.sir, e.arm, e.fail, $time);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] op, byp;
    logic         ar, ds, tp;
    resetN = 1'b0; zoneOpen = '0; zoneBypass = '0;
    armReq = 1'b0; disarmReq = 1'b0; tamper = 1'b0;
    m_edge = 0;
    model_reset();
    #1;
    chk("por_state", 32'(state), 32'd0);
    chk("por_outs", {alarmEnable, siren, armed, armFail}, 32'd0);
    repeat (2) @(posedge clk);

    // Arm refused while zone 2 is open.
    apply(8'h04, 8'h00, 1'b1, 1'b0, 1'b0);
    settle();
    chk("armfail_pulse", 32'(armFail), 32'd1);
    chk("armfail_state", 32'(state), 32'd0);
    apply(8'h04, 8'h00, 1'b0, 1'b0, 1'b0);
    settle();
    chk("armfail_drop", 32'(armFail), 32'd0);

    // Bypassed zone does not block arming; exit delay then ARMED.
    apply(8'h04, 8'h04, 1'b1, 1'b0, 1'b0);
    settle();
    chk("exit_enter", 32'(state), 32'd1);
    repeat (EXIT_DLY - 1) apply(8'h04, 8'h04, 1'b0, 1'b0, 1'b0);
    settle();
    chk("exit_last", 32'(state), 32'd1);
    apply(8'h04, 8'h04, 1'b0, 1'b0, 1'b0);
    settle();
    chk("armed_reached", 32'(state), 32'd2);

    // Full alarm cycle from a one-cycle opening of zone 0.
    apply(8'h05, 8'h04, 1'b0, 1'b0, 1'b0);
    settle();
    chk("entry_state", 32'(state), 32'd3);
    chk("entry_mem", 32'(alarmEnable), 32'h01);
    repeat (ENTRY_DLY) apply(8'h04, 8'h04, 1'b0, 1'b0, 1'b0);
    settle();
    chk("alarm_state", 32'(state), 32'd4);
    chk("alarm_siren", 32'(siren), 32'd1);
    repeat (SIREN_CYC) apply(8'h04, 8'h04, 1'b0, 1'b0, 1'b0);
    settle();
    chk("siren_end_state", 32'(state), 32'd2);
    chk("siren_end_siren", 32'(siren), 32'd0);
    chk("siren_end_mem", 32'(alarmEnable), 32'h01);

    // Disarm, re-arm (clears memory), then disarm during ENTRY.
    apply('0, '0, 1'b0, 1'b1, 1'b0);
    apply('0, '0, 1'b1, 1'b0, 1'b0);
    repeat (EXIT_DLY) apply('0, '0, 1'b0, 1'b0, 1'b0);
    apply(8'h10, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) apply('0, '0, 1'b0, 1'b0, 1'b0);
    apply('0, '0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("entry_disarm_state", 32'(state), 32'd0);
    chk("entry_disarm_mem", 32'(alarmEnable), 32'h10);
    apply('0, '0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("rearm_clears_mem", 32'(alarmEnable), 32'h00);

    // Disarm wins over arm while in EXIT.
    apply('0, '0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("prio_disarm", 32'(state), 32'd0);

    if (TAMPER_BUILD) begin
      apply('0, '0, 1'b0, 1'b0, 1'b1);
      settle();
      chk("tamper_state", 32'(state), 32'd4);
      chk("tamper_siren", 32'(siren), 32'd1);
      apply('0, '0, 1'b0, 1'b1, 1'b0);
    end

    // Reset in the middle of ENTRY.
    apply('0, '0, 1'b1, 1'b0, 1'b0);
    repeat (EXIT_DLY) apply('0, '0, 1'b0, 1'b0, 1'b0);
    apply(8'h80, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) apply('0, '0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      op  = ($urandom_range(0, 11) == 0) ? N'($urandom) : '0;
      byp = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : '0;
      ds  = ($urandom_range(0, 59) == 0);
      ar  = ($urandom_range(0, 5) == 0);
      tp  = TAMPER_BUILD && ($urandom_range(0, 299) == 0);
      if (m_mode == M_DIS && ds) ar = 1'b0;
      if ($urandom_range(0, 999) == 0) do_reset();
      else apply(op, byp, ar, ds, tp);
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never observed", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
